// File: rtl/stage3.sv
// stage3: GE pipeline stage 3 - effort integration, burnout watch and grading.
// Accepts stage-2 results in IDLE only; emits a one-cycle result strobe.
module stage3 #(
  parameter int         LOG2_CYC = 3,
  parameter logic [6:0] BURN_TH  = 7'd90,
  parameter int         BURN_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       pass2,
  input  logic [1:0] bonus2,
  input  logic [6:0] hard,
  input  logic [6:0] effort,
  output logic       busy,
  output logic       out_valid,
  output logic       pass3,
  output logic [1:0] grade
);

  localparam int NCYC = 2 ** LOG2_CYC;
  localparam int AW   = 7 + LOG2_CYC;
  localparam int SW   = $clog2(BURN_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    WORK,
    JUDGE,
    DONE
  } state_t;

  state_t state, nxt;

  logic [AW-1:0]       acc;
  logic [LOG2_CYC-1:0] cnt;
  logic [SW-1:0]       streak;
  logic [SW-1:0]       streak_nx;
  logic [6:0]          hard_q;
  logic [1:0]          bonus_q;
  logic                burn;

  logic       hot;
  logic       burn_hit;
  logic       last;
  logic [6:0] avg;
  logic [6:0] score;
  logic       pass_j;
  logic [1:0] grade_j;

  assign busy      = (state != IDLE);
  assign hot       = (effort > BURN_TH);
  assign streak_nx = hot ? streak + 1'b1 : '0;
  assign burn_hit  = hot && (streak_nx == SW'(BURN_LEN));
  assign last      = (cnt == LOG2_CYC'(NCYC - 1));

  // acc never exceeds 100*NCYC, so the top 7 bits are the truncated mean
  assign avg   = acc[AW-1:LOG2_CYC];
  assign score = avg + {3'b000, bonus_q, 2'b00};

  always_comb begin
    pass_j  = !burn && (score > hard_q);
    grade_j = 2'd0;
    if (pass_j) begin
      unique case (1'b1)
        (score >= 7'd90): grade_j = 2'd3;
        (score >= 7'd80 && score < 7'd90): grade_j = 2'd2;
        (score >= 7'd70 && score < 7'd80): grade_j = 2'd1;
        (score < 7'd70): grade_j = 2'd0;
        default: grade_j = 2'd0;
      endcase
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (in_valid) nxt = pass2 ? WORK : DONE;
      end
      WORK: begin
        if (burn_hit || last) nxt = JUDGE;
      end
      JUDGE: nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      streak    <= '0;
      hard_q    <= '0;
      bonus_q   <= '0;
      burn      <= 1'b0;
      out_valid <= 1'b0;
      pass3     <= 1'b0;
      grade     <= 2'd0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid && pass2) begin
            hard_q  <= hard;
            bonus_q <= bonus2;
            acc     <= '0;
            cnt     <= '0;
            streak  <= '0;
            burn    <= 1'b0;
          end else if (in_valid) begin
            pass3     <= 1'b0;
            grade     <= 2'd0;
            out_valid <= 1'b1;
          end
        end
        WORK: begin
          acc    <= acc + AW'(effort);
          cnt    <= cnt + 1'b1;
          streak <= streak_nx;
          if (burn_hit) burn <= 1'b1;
        end
        JUDGE: begin
          pass3     <= pass_j;
          grade     <= grade_j;
          out_valid <= 1'b1;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stage3.sv
// tb_stage3: randomized and directed checks of stage3 against a
// transaction-level model of latency, pass flag and grade.
module tb_stage3;

  localparam int NCYC = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b1;
  logic       pass2 = 1'b1;
  logic [1:0] bonus2 = 2'd0;
  logic [6:0] hard = 7'd0;
  logic [6:0] effort = 7'd0;
  logic       busy;
  logic       out_valid;
  logic       pass3;
  logic [1:0] grade;

  stage3 dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .pass2(pass2),
    .bonus2(bonus2),
    .hard(hard),
    .effort(effort),
    .busy(busy),
    .out_valid(out_valid),
    .pass3(pass3),
    .grade(grade)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // Transaction-level reference: latency in cycles after accept, pass, grade
  task automatic model(input bit p2, input int b, input int h,
                       input int eff[8], output int lat,
                       output int xp, output int xg);
    int sum, run, k, score;
    bit burnt;
    lat = 1; xp = 0; xg = 0;
    if (!p2) return;
    sum = 0; run = 0; k = NCYC; burnt = 0;
    for (int i = 0; i < NCYC; i++) begin
      sum += eff[i];
      run = (eff[i] > 90) ? run + 1 : 0;
      if (run == 3) begin
        burnt = 1;
        k = i + 1;
        break;
      end
    end
    lat = k + 2;
    score = sum / NCYC + 4 * b;
    xp = (!burnt && score > h) ? 1 : 0;
    if (xp == 1)
      xg = (score >= 90) ? 3 : (score >= 80) ? 2 : (score >= 70) ? 1 : 0;
  endtask

  // mode 0: plain, 1: in_valid pulse mid-WORK, 2: reset at sample 4
  task automatic run(input string tag, input bit p2, input int b,
                     input int h, input int eff[8], input int mode);
    int lat, xp, xg, ov_at, pulses, lim;
    model(p2, b, h, eff, lat, xp, xg);
    ov_at = -1;
    pulses = 0;
    lim = (mode == 2) ? 5 : lat + 1;
    @(negedge clk);
    in_valid = 1'b1;
    pass2 = p2;
    bonus2 = 2'(b);
    hard = 7'(h);
    effort = 7'($urandom_range(0, 100));
    for (int n = 1; n <= lim; n++) begin
      @(negedge clk);
      if (n == 1) begin
        in_valid = 1'b0;
        pass2 = 1'($urandom);
        bonus2 = 2'($urandom);
        hard = 7'($urandom_range(0, 100));
        chk({tag, ".busy_rise"}, busy, 1);
      end
      if (out_valid) begin
        pulses++;
        if (ov_at < 0) ov_at = n;
      end
      if (mode != 2 && n == lat) begin
        chk({tag, ".pass3"}, pass3, xp);
        chk({tag, ".grade"}, grade, xg);
      end
      if (mode != 2 && n == lat + 1) begin
        chk({tag, ".busy_fall"}, busy, 0);
        chk({tag, ".pass3_hold"}, pass3, xp);
        chk({tag, ".grade_hold"}, grade, xg);
      end
      if (mode == 2 && n == 5) begin
        chk({tag, ".abort_busy"}, busy, 0);
        chk({tag, ".abort_pass3"}, pass3, 0);
        rst = 1'b0;
      end
      effort = (n <= NCYC) ? 7'(eff[n-1]) : 7'($urandom_range(0, 100));
      if (mode == 1 && n == 3) begin
        in_valid = 1'b1;
        pass2 = 1'($urandom);
      end
      if (mode == 1 && n == 4) in_valid = 1'b0;
      if (mode == 2 && n == 4) rst = 1'b1;
    end
    if (mode == 2) begin
      for (int n = 0; n < 12; n++) begin
        @(negedge clk);
        if (out_valid) pulses++;
      end
      chk({tag, ".abort_no_ov"}, pulses, 0);
    end else begin
      chk({tag, ".ov_cycle"}, ov_at, lat);
      chk({tag, ".ov_count"}, pulses, 1);
    end
  endtask

  int e[8];
  int m;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.pass3", pass3, 0);
    chk("rst.grade", grade, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst.no_accept", busy, 0);

    e = '{default: 50};
    run("failfast", 1'b0, 3, 10, e, 0);
    e = '{default: 85};
    run("normal", 1'b1, 2, 70, e, 0);
    e = '{80, 81, 80, 81, 80, 81, 80, 81};
    run("equal", 1'b1, 0, 80, e, 0);
    e = '{95, 91, 50, 95, 95, 95, 10, 10};
    run("burnout", 1'b1, 3, 0, e, 0);
    e = '{default: 90};
    run("at_th", 1'b1, 0, 50, e, 0);
    e = '{default: 75};
    run("midpulse", 1'b1, 1, 60, e, 1);
    e = '{default: 88};
    run("abort", 1'b1, 1, 60, e, 2);
    e = '{default: 72};
    run("after_abort", 1'b1, 1, 60, e, 0);

    for (int t = 0; t < 60; t++) begin
      m = $urandom_range(0, 2);
      for (int i = 0; i < NCYC; i++)
        e[i] = (m == 0) ? $urandom_range(0, 100) : $urandom_range(60, 100);
      run("rand", ($urandom_range(0, 5) != 0), $urandom_range(0, 3),
          $urandom_range(0, 100), e, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
